ripple_carry_adder_4b: RTL and testbench



---
 rtl/rca_pkg.sv | 9 +
 rtl/ripple_carry_adder_4b_full_adder.sv | 16 +
 rtl/ripple_carry_adder_4b.sv | 54 +++++
 tb/tb_ripple_carry_adder_4b.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the 4-bit ripple-carry adder.
// Width is fixed; the word type is reused by every adder file.
package rca_pkg;

    localparam int RCA_WIDTH = 4;

    typedef logic [RCA_WIDTH-1:0] rca_word_t;

endpackage

// File: rtl/ripple_carry_adder_4b_full_adder.sv
// One-bit full adder; the building block of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_4b.sv
// Registered 4-bit ripple-carry adder with async active-low reset.
// Define RCA_OVERFLOW_EN to add the registered signed-overflow output.
module ripple_carry_adder_4b
    import rca_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  rca_word_t a,
    input  rca_word_t b,
    input  logic      c_in,
    output rca_word_t sum,
`ifdef RCA_OVERFLOW_EN
    output logic      overflow,
`endif
    output logic      c_out
);

    logic [RCA_WIDTH:0] c;
    rca_word_t          s;

    assign c[0] = c_in;

    for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            sum   <= s;
            c_out <= c[RCA_WIDTH];
        end
    end

`ifdef RCA_OVERFLOW_EN
    // Carry into and out of the sign bit disagree on signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= c[RCA_WIDTH-1] ^ c[RCA_WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_adder_4b.sv
// Scoreboard bench for ripple_carry_adder_4b.
// Expected {overflow, c_out, sum} is queued at drive time, popped after the edge.
module tb_ripple_carry_adder_4b;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] sum;
    logic       c_out;
    logic       ov_obs;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    ripple_carry_adder_4b dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .sum     (sum),
`ifdef RCA_OVERFLOW_EN
        .overflow(ov_obs),
`endif
        .c_out   (c_out)
    );

`ifndef RCA_OVERFLOW_EN
    assign ov_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] model(input logic [3:0] ta,
                                         input logic [3:0] tb,
                                         input logic tc);
        logic [4:0] r;
        logic       ov;
        r  = {1'b0, ta} + {1'b0, tb} + {4'b0, tc};
        ov = (ta[3] == tb[3]) && (r[3] != ta[3]);
`ifndef RCA_OVERFLOW_EN
        ov = 1'b0;
`endif
        return {ov, r};
    endfunction

    function automatic logic [5:0] observed();
        return {ov_obs, c_out, sum};
    endfunction

    task automatic check(input string tag, input logic [5:0] got,
                         input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb,
                         input logic tc, input string tag);
        a    = ta;
        b    = tb;
        c_in = tc;
        exp_q.push_back(model(ta, tb, tc));
        tag_q.push_back(tag);
    endtask

    task automatic compare();
        if (exp_q.size() == 0) begin
            check("sb_empty", observed(), 6'bx);
        end else begin
            check(tag_q.pop_front(), observed(), exp_q.pop_front());
        end
    endtask

    task automatic step(input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc, input string tag);
        @(negedge clk);
        drive(ta, tb, tc, tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 4'b1111;
        b     = 4'b1111;
        c_in  = 1'b1;

        #1;
        check("rst_async", observed(), 6'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", observed(), 6'b0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1, "rst_release");
        @(posedge clk);
        #1;
        compare();

        step(4'b0100, 4'b1010, 1'b0, "nocarry0");
        step(4'b0010, 4'b0001, 1'b0, "nocarry1");
        step(4'b1000, 4'b1001, 1'b0, "carry_out");
        step(4'b1111, 4'b0001, 1'b1, "ripple0");
        step(4'b1010, 4'b1101, 1'b1, "ripple1");
        step(4'b0000, 4'b0000, 1'b0, "zero");

        step(4'b0010, 4'b1001, 1'b1, "pipe0");
        step(4'b0100, 4'b0010, 1'b1, "pipe1");
        step(4'b0101, 4'b0011, 1'b1, "pipe2");

        @(negedge clk);
        #1;
        check("hold_const", observed(), model(4'b0101, 4'b0011, 1'b1));

        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            drive(i[3:0], i[7:4], i[8], "sweep");
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1 check("rst_mid", observed(), 6'b0);
                #1 rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            compare();
        end

        if (exp_q.size() != 0)
            check("sb_leftover", 6'(exp_q.size()), 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
